// File: rtl/traffic_lanes_if.sv
// rtl/traffic_lanes_if.sv - control, query and pixel bundle for traffic_lanes
interface traffic_lanes_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int DIV_W = 8
);
  logic                       enable;
  logic                       seed_load;
  logic [15:0]                seed;
  logic [LANES-1:0]           lane_dir;
  logic [LANES*DIV_W-1:0]     lane_period;
  logic [4:0]                 density;
  logic [2:0]                 frog_lane;
  logic [$clog2(WIDTH)-1:0]   frog_col;
  logic [LANES*WIDTH-1:0]     pixels;
  logic [LANES-1:0]           lane_step;
  logic                       hit;

  modport master (
    output enable, seed_load, seed, lane_dir, lane_period, density, frog_lane, frog_col,
    input  pixels, lane_step, hit
  );

  modport slave (
    input  enable, seed_load, seed, lane_dir, lane_period, density, frog_lane, frog_col,
    output pixels, lane_step, hit
  );
endinterface

// File: rtl/traffic_lanes.sv
// rtl/traffic_lanes.sv - LFSR-spawned scrolling car lanes; TRAFFIC_HIT_EN enables the cell query
module traffic_lanes #(
  parameter int WIDTH   = 16,
  parameter int LANES   = 4,
  parameter int DIV_W   = 8,
  parameter int MIN_GAP = 2
) (
  input  logic            clock,
  input  logic            reset,
  traffic_lanes_if.slave  bus
);
  localparam int GAP_W = $clog2(MIN_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MIN_GAP);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  logic [15:0]            lfsr_q, lfsr_d;
  logic [LANES*WIDTH-1:0] pixels_q, pixels_d;
  logic [LANES-1:0]       lane_step_q, lane_step_d;
  logic [DIV_W-1:0]       cnt_q [LANES];
  logic [DIV_W-1:0]       cnt_d [LANES];
  logic [GAP_W-1:0]       gap_q [LANES];
  logic [GAP_W-1:0]       gap_d [LANES];
  logic                   hit_q, hit_d;

  always_comb begin
    logic [DIV_W-1:0] period;
    logic [WIDTH-1:0] lane;
    logic             spawn;
    logic             ins;
    lfsr_d      = lfsr_q;
    pixels_d    = pixels_q;
    lane_step_d = '0;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    period      = '0;
    lane        = '0;
    spawn       = 1'b0;
    ins         = 1'b0;

    if (bus.seed_load) begin
      lfsr_d = (bus.seed == 16'h0) ? LFSR_INIT : bus.seed;
    end else if (bus.enable) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    if (bus.enable) begin
      for (int i = 0; i < LANES; i++) begin
        period = bus.lane_period[i*DIV_W +: DIV_W];
        lane   = pixels_q[i*WIDTH +: WIDTH];
        // ">=" lets a counter stranded above a freshly lowered period wrap at once
        if (cnt_q[i] >= period) begin
          cnt_d[i]       = '0;
          lane_step_d[i] = 1'b1;
          spawn          = ({1'b0, lfsr_q[4*(i%4) +: 4]} < bus.density);
          ins            = spawn && (gap_q[i] >= GAP_SAT);
          if (ins)
            gap_d[i] = '0;
          else if (gap_q[i] >= GAP_SAT)
            gap_d[i] = GAP_SAT;
          else
            gap_d[i] = gap_q[i] + 1'b1;
          pixels_d[i*WIDTH +: WIDTH] = bus.lane_dir[i] ? {ins, lane[WIDTH-1:1]}
                                                       : {lane[WIDTH-2:0], ins};
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef TRAFFIC_HIT_EN
  always_comb begin
    hit_d = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if ((int'(bus.frog_lane) == l) && (int'(bus.frog_col) == c))
          hit_d = pixels_q[l*WIDTH + c];
      end
    end
  end
`else
  logic unused_frog;
  assign unused_frog = ^{bus.frog_lane, bus.frog_col};
  assign hit_d = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q      <= LFSR_INIT;
      pixels_q    <= '0;
      lane_step_q <= '0;
      hit_q       <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i] <= '0;
        gap_q[i] <= GAP_SAT;
      end
    end else begin
      lfsr_q      <= lfsr_d;
      pixels_q    <= pixels_d;
      lane_step_q <= lane_step_d;
      hit_q       <= hit_d;
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
        gap_q[i] <= gap_d[i];
      end
    end
  end

  assign bus.pixels    = pixels_q;
  assign bus.lane_step = lane_step_q;
  assign bus.hit       = hit_q;
endmodule

// File: doc/traffic_lanes.md
TRAFFIC_LANES -- requirements
Module: traffic_lanes

Interface
REQ-001 Parameter WIDTH, 16, cells per lane (>=4).
REQ-002 Parameter LANES, 4, number of independent lanes (1..8).
REQ-003 Parameter DIV_W, 8, width of each lane speed-divider period field.
REQ-004 Parameter MIN_GAP, 2, minimum empty cells inserted after each car cell (0..WIDTH-1).
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  global run; low freezes all state.
REQ-008 seed_load  in  1  load seed into LFSR this cycle.
REQ-009 seed  in  16  LFSR seed value.
REQ-010 lane_dir  in  LANES  per lane: 0 = cars enter at bit 0 and move toward MSB, 1 = enter at bit WIDTH-1 and move toward LSB.
REQ-011 lane_period  in  LANES*DIV_W  per lane step period minus one; lane i uses bits [i*DIV_W +: DIV_W].
REQ-012 density  in  5  spawn threshold; 0 = never, >=16 = always.
REQ-013 frog_lane  in  3  queried lane index.
REQ-014 frog_col  in  clog2(WIDTH)  queried cell index.
REQ-015 pixels  out  LANES*WIDTH  lane i occupancy at [i*WIDTH +: WIDTH], 1 = car.
REQ-016 lane_step  out  LANES  one-cycle pulse in the cycle lane i's pixels update.
REQ-017 hit  out  1  registered occupancy of the queried cell.

Function
REQ-018 LFSR: 16-bit Galois, mask 16'hB400, shifts right once per cycle while enable=1; seed_load (priority over enable) loads seed, or 16'hACE1 when seed==0.
REQ-019 Per-lane divider counter: while enable=1, counter==period -> counter:=0 and step; else counter+1; period 0 = step every enabled cycle.
REQ-020 Spawn request for lane i = (LFSR[4*(i mod 4) +: 4] < density), sampled in the step cycle.
REQ-021 Inserted bit = spawn request AND gap counter >= MIN_GAP; gap counter clears to 0 on inserting 1, else increments, saturating at MIN_GAP.
REQ-022 On step: dir 0 -> {lane[WIDTH-2:0], ins}; dir 1 -> {ins, lane[WIDTH-1:1]}; exiting bit discarded.
REQ-023 lane_step[i] registered, asserted in the same cycle the new lane value is first visible on pixels.
REQ-024 lane_dir changes take effect at the lane's next step; lane contents not altered by the change.
REQ-025 lane_period changes apply immediately; if counter > new period, counter wraps to 0 on the next enabled cycle with a step.
REQ-026 enable=0: pixels, counters, gap counters, LFSR hold; lane_step all 0; hit still updates.
REQ-027 hit latency 1 cycle: hit := pixels[frog_lane*WIDTH+frog_col] of the current registered value; 0 when frog_lane>=LANES or frog_col>=WIDTH.

Reset
REQ-028 reset (overrides enable and seed_load): pixels=0, lane_step=0, hit=0, divider counters=0, gap counters=MIN_GAP, LFSR=16'hACE1.
REQ-029 reset mid-operation discards all lane contents in one cycle; first step afterward may spawn.

Configuration
REQ-030 Macro TRAFFIC_HIT_EN defined: hit logic per REQ-027 compiled in.
REQ-031 TRAFFIC_HIT_EN undefined: hit logic removed, hit constant 0, frog_lane/frog_col ignored; all other behaviour identical.

Verification (WIDTH=16, LANES=4, MIN_GAP=2)
REQ-032 reset, density=0, periods=0, enable=1 for 40 cycles -> pixels stay 0, lane_step=4'b1111 every cycle.
REQ-033 density=16, lane 0 period 0 dir 0, 16 enabled cycles after reset -> lane 0 = 16'h9249.
REQ-034 density=16, lane 1 dir 1 period 0, one step after reset -> lane 1 = 16'h8000; lane 2 period 3 -> lane_step[2] every 4th cycle; enable low 5 cycles mid-count -> step delayed by exactly 5 cycles.
REQ-035 lane 0 = 16'h9249, frog_lane=0: frog_col=0 -> hit=1 next cycle, frog_col=1 -> hit=0, frog_lane=5 -> hit=0; with TRAFFIC_HIT_EN undefined hit=0 throughout.
REQ-036 seed_load with seed=0 -> LFSR=16'hACE1; reset asserted mid-run with lanes non-zero -> next cycle all pixels 0, lane_step 0, hit 0.
